// File: rtl/marks_pkg.sv
// Shared types and constants for the college marks channel.
// Holds mark limits, grade thresholds, grade codes and reader FSM states.
package marks_pkg;

    localparam int MARK_W_DEF  = 8;
    localparam int MAX_MARK    = 100;
    localparam int PASS_MARK   = 35;

    localparam int GRADE_A_MIN = 270;
    localparam int GRADE_B_MIN = 240;
    localparam int GRADE_C_MIN = 210;
    localparam int GRADE_D_MIN = 180;

    typedef enum logic [2:0] {
        G_A,
        G_B,
        G_C,
        G_D,
        G_F,
        G_INV
    } grade_e;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        GRADE,
        OUT
    } state_e;

endpackage

// File: rtl/mark_grader.sv
// Combinational grade lookup from total and per-mark flags.
// Ports: total (TOTAL_W), fail, invalid in; grade (grade_e) out.
module mark_grader
    import marks_pkg::*;
#(
    parameter int TOTAL_W = MARK_W_DEF + 2
) (
    input  logic [TOTAL_W-1:0] total,
    input  logic               fail,
    input  logic               invalid,
    output grade_e             grade
);

    localparam logic [TOTAL_W-1:0] A_MIN = TOTAL_W'(GRADE_A_MIN);
    localparam logic [TOTAL_W-1:0] B_MIN = TOTAL_W'(GRADE_B_MIN);
    localparam logic [TOTAL_W-1:0] C_MIN = TOTAL_W'(GRADE_C_MIN);
    localparam logic [TOTAL_W-1:0] D_MIN = TOTAL_W'(GRADE_D_MIN);

    // Ordered: an out-of-range mark outranks a failing mark,
    // which outranks any total-based grade.
    always_comb begin
        grade = G_F;
        if (invalid) begin
            grade = G_INV;
        end else if (fail) begin
            grade = G_F;
        end else if (total >= A_MIN) begin
            grade = G_A;
        end else if (total >= B_MIN) begin
            grade = G_B;
        end else if (total >= C_MIN) begin
            grade = G_C;
        end else if (total >= D_MIN) begin
            grade = G_D;
        end else begin
            grade = G_F;
        end
    end

endmodule

// File: rtl/report_card_reader.sv
// Reading end of the marks channel: accepts one report, grades it,
// and offers the result downstream.
// Ports: clk, rst_n; in_valid/in_ready with math/physics/lab in;
// res_valid/res_ready with res_total/grade/fail/invalid out;
// report_cnt = saturating count of results taken downstream.
module report_card_reader
    import marks_pkg::*;
#(
    parameter int MARK_W = MARK_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MARK_W-1:0] math,
    input  logic [MARK_W-1:0] physics,
    input  logic [MARK_W-1:0] lab,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [MARK_W+1:0] res_total,
    output grade_e            res_grade,
    output logic              res_fail,
    output logic              res_invalid,
    output logic [CNT_W-1:0]  report_cnt
);

    localparam int TOTAL_W = MARK_W + 2;

    localparam logic [MARK_W-1:0] MAX_M  = MARK_W'(MAX_MARK);
    localparam logic [MARK_W-1:0] PASS_M = MARK_W'(PASS_MARK);

    state_e              state_q, state_d;
    logic [MARK_W-1:0]   m_q, m_d;
    logic [MARK_W-1:0]   p_q, p_d;
    logic [MARK_W-1:0]   l_q, l_d;
    logic [TOTAL_W-1:0]  total_q, total_d;
    logic                fail_q, fail_d;
    logic                inv_q, inv_d;
    grade_e              grade_q, grade_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    grade_e              grade_w;

    mark_grader #(
        .TOTAL_W (TOTAL_W)
    ) u_grader (
        .total   (total_q),
        .fail    (fail_q),
        .invalid (inv_q),
        .grade   (grade_w)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        l_d     = l_q;
        total_d = total_q;
        fail_d  = fail_q;
        inv_d   = inv_q;
        grade_d = grade_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = math;
                    p_d     = physics;
                    l_d     = lab;
                    state_d = SUM;
                end
            end
            SUM: begin
                // Three marks fit in two extra bits, no overflow.
                total_d = TOTAL_W'(m_q)
                        + TOTAL_W'(p_q)
                        + TOTAL_W'(l_q);
                inv_d   = (m_q > MAX_M)
                       || (p_q > MAX_M)
                       || (l_q > MAX_M);
                fail_d  = (m_q < PASS_M)
                       || (p_q < PASS_M)
                       || (l_q < PASS_M);
                state_d = GRADE;
            end
            GRADE: begin
                grade_d = grade_w;
                state_d = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_q     <= '0;
            l_q     <= '0;
            total_q <= '0;
            fail_q  <= 1'b0;
            inv_q   <= 1'b0;
            grade_q <= G_F;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            l_q     <= l_d;
            total_q <= total_d;
            fail_q  <= fail_d;
            inv_q   <= inv_d;
            grade_q <= grade_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign res_valid   = (state_q == OUT);
    assign res_total   = total_q;
    assign res_grade   = grade_q;
    assign res_fail    = fail_q;
    assign res_invalid = inv_q;
    assign report_cnt  = cnt_q;

endmodule

// File: tb/tb_report_card_reader.sv
// Scoreboard bench for report_card_reader.
// Directed reports; a monitor checks each delivered result.
module tb_report_card_reader;
    import marks_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, res_valid, res_ready;
    logic [7:0] math, physics, lab;
    logic [9:0] res_total;
    grade_e     res_grade;
    logic       res_fail, res_invalid;
    logic [15:0] report_cnt;

    logic       in_valid2, in_ready2, res_valid2, res_ready2;
    logic [7:0] math2, physics2, lab2;
    logic [9:0] res_total2;
    grade_e     res_grade2;
    logic       res_fail2, res_invalid2;
    logic [1:0] report_cnt2;

    report_card_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .math        (math),
        .physics     (physics),
        .lab         (lab),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_total   (res_total),
        .res_grade   (res_grade),
        .res_fail    (res_fail),
        .res_invalid (res_invalid),
        .report_cnt  (report_cnt)
    );

    report_card_reader #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .math        (math2),
        .physics     (physics2),
        .lab         (lab2),
        .res_valid   (res_valid2),
        .res_ready   (res_ready2),
        .res_total   (res_total2),
        .res_grade   (res_grade2),
        .res_fail    (res_fail2),
        .res_invalid (res_invalid2),
        .report_cnt  (report_cnt2)
    );

    typedef struct {
        logic [9:0] total;
        grade_e     grade;
        logic       fail;
        logic       inv;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    int n_done = 0;
    int done_tgt = 0;
    int exp_cnt = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: a result is delivered on the edge after this sample.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got total %0d expected none",
                         res_total);
            end else begin
                e = sb.pop_front();
                check("res_total", 32'(res_total), 32'(e.total));
                check("res_grade", 32'(res_grade), 32'(e.grade));
                check("res_fail", 32'(res_fail), 32'(e.fail));
                check("res_invalid", 32'(res_invalid), 32'(e.inv));
                n_done++;
            end
        end
    end

    task automatic send(input logic [7:0] m, p, l,
                        input logic [9:0] t, input grade_e g,
                        input logic f, i, input bit push);
        int k;
        exp_t e;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 50) timeout("in_ready_wait");
        math = m;
        physics = p;
        lab = l;
        in_valid = 1'b1;
        if (push) begin
            e.total = t;
            e.grade = g;
            e.fail = f;
            e.inv = i;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        math = 8'($urandom);
        physics = 8'($urandom);
        lab = 8'($urandom);
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (n_done < target && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) timeout("result_wait");
    endtask

    task automatic run(input logic [7:0] m, p, l,
                       input logic [9:0] t, input grade_e g,
                       input logic f, i);
        send(m, p, l, t, g, f, i, 1'b1);
        done_tgt++;
        wait_done(done_tgt);
        exp_cnt++;
        check("report_cnt", 32'(report_cnt), 32'(exp_cnt));
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int k;
        in_valid = 0;
        math = 0;
        physics = 0;
        lab = 0;
        res_ready = 1;
        in_valid2 = 0;
        math2 = 50;
        physics2 = 50;
        lab2 = 50;
        res_ready2 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_total", 32'(res_total), 32'd0);
        check("rst_grade", 32'(res_grade), 32'(G_F));
        check("rst_fail", 32'(res_fail), 32'd0);
        check("rst_invalid", 32'(res_invalid), 32'd0);
        check("rst_cnt", 32'(report_cnt), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // First report: latency counted in negedge samples.
        send(85, 90, 95, 270, G_A, 0, 0, 1'b1);
        lat = 1;
        @(negedge clk);
        while (!res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        @(posedge clk);
        #1;
        done_tgt++;
        wait_done(done_tgt);
        exp_cnt++;
        check("report_cnt", 32'(report_cnt), 32'(exp_cnt));
        check("in_ready_after", 32'(in_ready), 32'd1);

        run(85, 90, 99, 274, G_A, 0, 0);
        run(85, 90, 30, 205, G_F, 1, 0);
        run(101, 50, 50, 201, G_INV, 0, 1);
        run(0, 0, 0, 0, G_F, 1, 0);
        run(80, 80, 80, 240, G_B, 0, 0);
        run(80, 80, 79, 239, G_C, 0, 0);
        run(70, 70, 70, 210, G_C, 0, 0);
        run(60, 60, 60, 180, G_D, 0, 0);
        run(59, 60, 60, 179, G_F, 0, 0);
        run(100, 100, 100, 300, G_A, 0, 0);
        run(35, 35, 35, 105, G_F, 0, 0);
        run(34, 100, 100, 234, G_F, 1, 0);
        run(120, 20, 100, 240, G_INV, 1, 1);

        // Backpressure: held in OUT, busy in_valid ignored.
        res_ready = 0;
        send(80, 80, 80, 240, G_B, 0, 0, 1'b1);
        k = 0;
        while (!res_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 20) timeout("bp_valid_wait");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1;
            math = 8'(c * 7);
            physics = 8'(c * 3);
            lab = 8'(c);
            @(posedge clk);
            #1;
            check("bp_hold",
                  {16'd0, res_valid, in_ready, res_total,
                   res_grade, res_fail, res_invalid},
                  {16'd0, 1'b1, 1'b0, 10'd240,
                   G_B, 1'b0, 1'b0});
            check("bp_cnt", 32'(report_cnt), 32'(exp_cnt));
        end
        in_valid = 0;
        res_ready = 1;
        done_tgt++;
        wait_done(done_tgt);
        exp_cnt++;
        check("bp_cnt_after", 32'(report_cnt), 32'(exp_cnt));
        check("bp_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_extra", 32'(n_done), 32'(done_tgt));

        // Reset asserted while the report sits in GRADE.
        send(85, 90, 95, 270, G_A, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        check("grade_busy", 32'(in_ready), 32'd0);
        rst_n = 0;
        #1;
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_total", 32'(res_total), 32'd0);
        check("mid_grade", 32'(res_grade), 32'(G_F));
        check("mid_fail", 32'(res_fail), 32'd0);
        check("mid_invalid", 32'(res_invalid), 32'd0);
        check("mid_cnt", 32'(report_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (6) @(posedge clk);
        #1;
        check("mid_no_result", 32'(n_done), 32'(done_tgt));
        check("mid_valid_low", 32'(res_valid), 32'd0);

        // Two-bit counter saturation.
        for (int r = 1; r <= 5; r++) begin
            in_valid2 = 1;
            @(posedge clk);
            #1;
            in_valid2 = 0;
            k = 0;
            while (!res_valid2 && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (k >= 20) timeout("sat_valid_wait");
            check("sat_total", 32'(res_total2), 32'd150);
            @(posedge clk);
            #1;
            check("sat_cnt", 32'(report_cnt2),
                  32'((r < 3) ? r : 3));
        end

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
